// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver: 16 sample ticks per bit, optional parity, and a one-entry
// holding register with a valid/ready handshake plus parity, framing and overrun flags.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | line idle, waiting for a tick that sees the line low
// START     | qualifying the start bit at mid-bit (sample count 7)
// DATA      | sampling 8 data bits, LSB first, at sample count 15
// PARITY    | sampling the parity bit
// STOP      | sampling the stop bit, then handing the byte to delivery
// WAIT_HIGH | stop bit was low (break), waiting for the line to go high
module uart_rx_sampler #(
    parameter int CLKS_PER_SAMPLE = 4,
    parameter bit PARITY_EN       = 1'b1,
    parameter bit PARITY_ODD      = 1'b0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       SerialIn,
    output logic [7:0] DataOut,
    output logic       RxValid,
    input  logic       RxReady,
    output logic       RxBusy,
    output logic       ParityError,
    output logic       FrameError,
    output logic       Overrun
);

    localparam int TW = (CLKS_PER_SAMPLE > 2) ? $clog2(CLKS_PER_SAMPLE) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_SAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t          state, state_next;
    logic            sync_q1, line;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [3:0]      samp_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;
    logic            par_err_q, frame_err_q, deliver;
    logic            cnt_clr, cnt_inc, shift_en, par_smp, stop_smp;
    logic            handshake;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync_q1 <= 1'b1;
            line    <= 1'b1;
        end else begin
            sync_q1 <= SerialIn;
            line    <= sync_q1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            tick_cnt <= '0;
        else if (tick_cnt == TICK_LAST)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        shift_en   = 1'b0;
        par_smp    = 1'b0;
        stop_smp   = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick && !line) begin
                    state_next = S_START;
                    cnt_clr    = 1'b1;
                end
            end
            S_START: begin
                if (tick) begin
                    if (samp_cnt == 4'd7) begin
                        if (line) begin
                            state_next = S_IDLE;
                        end else begin
                            state_next = S_DATA;
                            cnt_clr    = 1'b1;
                        end
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    cnt_inc = 1'b1;
                    if (samp_cnt == 4'd15) begin
                        shift_en = 1'b1;
                        if (bit_cnt == 3'd7)
                            state_next = PARITY_EN ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    cnt_inc = 1'b1;
                    if (samp_cnt == 4'd15) begin
                        par_smp    = 1'b1;
                        state_next = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    cnt_inc = 1'b1;
                    if (samp_cnt == 4'd15) begin
                        stop_smp   = 1'b1;
                        state_next = line ? S_IDLE : S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (tick && line)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Frame datapath; the sample count wraps 15 -> 0 naturally between bits.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            samp_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            deliver     <= 1'b0;
        end else begin
            deliver <= stop_smp;
            if (cnt_clr) begin
                samp_cnt  <= '0;
                bit_cnt   <= '0;
                par_err_q <= 1'b0;
            end else if (cnt_inc) begin
                samp_cnt <= samp_cnt + 1'b1;
            end
            if (shift_en) begin
                shift_reg <= {line, shift_reg[7:1]};
                bit_cnt   <= bit_cnt + 1'b1;
            end
            if (par_smp)
                par_err_q <= ((^shift_reg) ^ line) != PARITY_ODD;
            if (stop_smp)
                frame_err_q <= ~line;
        end
    end

    assign handshake = RxValid & RxReady;

    // A byte can be accepted in the same cycle the consumer drains the previous one.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            DataOut     <= '0;
            RxValid     <= 1'b0;
            ParityError <= 1'b0;
            FrameError  <= 1'b0;
            Overrun     <= 1'b0;
        end else begin
            if (handshake)
                Overrun <= 1'b0;
            if (deliver && (!RxValid || RxReady)) begin
                DataOut     <= shift_reg;
                ParityError <= par_err_q;
                FrameError  <= frame_err_q;
                RxValid     <= 1'b1;
            end else if (deliver) begin
                Overrun <= 1'b1;
            end else if (handshake) begin
                RxValid <= 1'b0;
            end
        end
    end

    assign RxBusy = (state == S_START) || (state == S_DATA) ||
                    (state == S_PARITY) || (state == S_STOP);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: good frame, parity error, glitch, framing/break,
// overrun and reset mid-frame, with hand-computed expected values.
module tb_uart_rx_sampler;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       SerialIn = 1'b1;
    logic [7:0] DataOut;
    logic       RxValid;
    logic       RxReady = 1'b0;
    logic       RxBusy;
    logic       ParityError;
    logic       FrameError;
    logic       Overrun;

    int n_cmp = 0;
    int n_err = 0;
    logic busy_seen;

    uart_rx_sampler #(
        .CLKS_PER_SAMPLE(4),
        .PARITY_EN(1'b1),
        .PARITY_ODD(1'b0)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .SerialIn(SerialIn),
        .DataOut(DataOut),
        .RxValid(RxValid),
        .RxReady(RxReady),
        .RxBusy(RxBusy),
        .ParityError(ParityError),
        .FrameError(FrameError),
        .Overrun(Overrun)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        #1 SerialIn = b;
        repeat (64) @(posedge Clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        drive_bit(par);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        #1 SerialIn = 1'b1;
        repeat (n) @(posedge Clk);
    endtask

    task automatic consume();
        @(negedge Clk);
        RxReady = 1'b1;
        @(negedge Clk);
        RxReady = 1'b0;
    endtask

    task automatic chk_byte(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        @(negedge Clk);
        chk({tag, "_data"}, DataOut, d);
        chk({tag, "_valid"}, RxValid, 1'b1);
        chk({tag, "_perr"}, ParityError, pe);
        chk({tag, "_ferr"}, FrameError, fe);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_data"}, DataOut, 8'h00);
        chk({tag, "_valid"}, RxValid, 1'b0);
        chk({tag, "_busy"}, RxBusy, 1'b0);
        chk({tag, "_perr"}, ParityError, 1'b0);
        chk({tag, "_ferr"}, FrameError, 1'b0);
        chk({tag, "_ovr"}, Overrun, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        chk_reset("rst");
        Reset = 1'b1;
        idle(100);

        // 1: good frame, 0x8E has four ones -> even parity bit 0
        send_frame(8'h8E, 1'b0, 1'b1);
        chk_byte("good", 8'h8E, 1'b0, 1'b0);
        chk("good_ovr", Overrun, 1'b0);
        consume();
        chk("good_ack_valid", RxValid, 1'b0);

        // 2: parity error
        send_frame(8'h8E, 1'b1, 1'b1);
        chk_byte("perr", 8'h8E, 1'b1, 1'b0);
        consume();
        chk("perr_ack_valid", RxValid, 1'b0);

        // 3: 16-clock glitch must be rejected
        busy_seen = 1'b0;
        #1 SerialIn = 1'b0;
        repeat (16) begin
            @(negedge Clk);
            busy_seen |= RxBusy;
        end
        SerialIn = 1'b1;
        repeat (80) begin
            @(negedge Clk);
            busy_seen |= RxBusy;
        end
        chk("glitch_busy_pulse", busy_seen, 1'b1);
        chk("glitch_busy_end", RxBusy, 1'b0);
        chk("glitch_valid", RxValid, 1'b0);
        chk("glitch_data", DataOut, 8'h8E);

        // 4: framing error followed by a held-low break
        send_frame(8'h3C, 1'b0, 1'b0);
        busy_seen = 1'b0;
        repeat (200) begin
            @(negedge Clk);
            busy_seen |= RxBusy;
        end
        chk("brk_no_busy", busy_seen, 1'b0);
        chk_byte("ferr", 8'h3C, 1'b0, 1'b1);
        consume();
        idle(64);
        send_frame(8'h01, 1'b1, 1'b1);
        chk_byte("after_brk", 8'h01, 1'b0, 1'b0);
        consume();
        chk("after_brk_ack", RxValid, 1'b0);

        // 5: overrun with back-to-back frames
        send_frame(8'h55, 1'b0, 1'b1);
        send_frame(8'hA3, 1'b0, 1'b1);
        chk_byte("ovr", 8'h55, 1'b0, 1'b0);
        chk("ovr_flag", Overrun, 1'b1);
        consume();
        chk("ovr_ack_valid", RxValid, 1'b0);
        chk("ovr_ack_flag", Overrun, 1'b0);

        // 6: reset after 4 data bits of 0xF0
        idle(64);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        @(negedge Clk);
        chk("mid_busy", RxBusy, 1'b1);
        Reset = 1'b0;
        SerialIn = 1'b1;
        @(negedge Clk);
        chk_reset("midrst");
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        idle(64);
        chk("midrst_no_valid", RxValid, 1'b0);
        send_frame(8'h81, 1'b0, 1'b1);
        chk_byte("post_rst", 8'h81, 1'b0, 1'b0);
        chk("post_rst_ovr", Overrun, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
